nonce_dispatch: RTL

NONCE_DISPATCH -- requirements
Module: nonce_dispatch

---
 rtl/nonce_dispatch.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/nonce_dispatch.sv
// Nonce range dispatcher: hands fixed-size nonce chunks to hash lanes, collects
// golden-nonce hits into per-lane hold registers and a shared result FIFO.
module nonce_dispatch #(
    parameter int LANES      = 4,
    parameter int CHUNK_LOG2 = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_FIRST = 1
) (
    input  logic                hash_clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [31:0]         nonce_start,
    input  logic [31:0]         nonce_limit,
    output logic [LANES-1:0]    lane_load,
    output logic [32*LANES-1:0] lane_base,
    input  logic [LANES-1:0]    lane_hit,
    input  logic [32*LANES-1:0] lane_hit_nonce,
    input  logic [LANES-1:0]    lane_done,
    output logic                res_valid,
    output logic [31:0]         res_nonce,
    output logic [2:0]          res_lane,
    input  logic                res_ready,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [15:0]         hit_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [32:0] CHUNK = 33'd1 << CHUNK_LOG2;
    localparam logic [AW:0] FIFO_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_r;
    logic                  busy_r, done_r, exhausted_r, stopped_r, overflow_r;
    logic [31:0]           next_base_r, limit_r;
    logic [15:0]           hit_count_r;
    logic [LANES-1:0]      lane_busy_r, hold_valid_r, lane_load_r;
    logic [32*LANES-1:0]   lane_base_r;
    logic [31:0]           hold_nonce_r [LANES];
    logic [2:0]            rr_ptr_r;
    logic [31:0]           fifo_nonce_r [FIFO_DEPTH];
    logic [2:0]            fifo_lane_r  [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
    logic [AW:0]           fifo_cnt_r;

    logic                  start_ok_s, active_s, pop_s, can_push_s, push_s;
    logic                  xfer_s, can_load_s, stop_now_s, exhaust_now_s;
    logic [2:0]            xfer_lane_s;
    logic [LANES-1:0]      drain_sel_s, capture_s, drop_s, load_sel_s;
    logic [3:0]            hits_s;
    logic [16:0]           hit_sum_s;
    logic [32:0]           sum_s;

    assign start_ok_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign active_s      = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign res_valid     = (fifo_cnt_r != '0);
    assign pop_s         = res_valid && res_ready;
    assign can_push_s    = (fifo_cnt_r != FIFO_FULL) || pop_s;
    assign push_s        = xfer_s && can_push_s;
    assign sum_s         = {1'b0, next_base_r} + CHUNK;
    assign exhaust_now_s = sum_s[32] || (sum_s[31:0] > limit_r);
    assign capture_s     = active_s ? (lane_hit & (~hold_valid_r | drain_sel_s)) : '0;
    assign drop_s        = active_s ? (lane_hit & hold_valid_r & ~drain_sel_s) : '0;
    assign stop_now_s    = (STOP_FIRST != 0) && (|capture_s);
    assign can_load_s    = (state_r == ST_RUN) && !exhausted_r && !stopped_r && !stop_now_s;
    assign hit_sum_s     = {1'b0, hit_count_r} + {13'd0, hits_s};

    // Round-robin pick of the next valid hold register, starting after the last served lane.
    always_comb begin
        xfer_s      = 1'b0;
        xfer_lane_s = 3'd0;
        for (int k = 1; k <= LANES; k++) begin
            xfer_lane_s = (!xfer_s && hold_valid_r[(int'(rr_ptr_r) + k) % LANES])
                        ? 3'((int'(rr_ptr_r) + k) % LANES) : xfer_lane_s;
            xfer_s      = xfer_s | hold_valid_r[(int'(rr_ptr_r) + k) % LANES];
        end
    end

    // Per-lane decode: drained hold, lowest idle lane to load, and captured-hit count.
    always_comb begin
        logic found;
        found       = 1'b0;
        hits_s      = 4'd0;
        drain_sel_s = '0;
        load_sel_s  = '0;
        for (int i = 0; i < LANES; i++) begin
            drain_sel_s[i] = push_s && (xfer_lane_s == 3'(i));
            load_sel_s[i]  = can_load_s && !lane_busy_r[i] && !found;
            found          = found | !lane_busy_r[i];
            hits_s         = hits_s + {3'd0, capture_s[i]};
        end
    end

    // Search control FSM, dispatch registers and status outputs.
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            exhausted_r <= 1'b0;
            stopped_r   <= 1'b0;
            overflow_r  <= 1'b0;
            next_base_r <= 32'd0;
            limit_r     <= 32'd0;
            hit_count_r <= 16'd0;
            lane_busy_r <= '0;
            lane_load_r <= '0;
            lane_base_r <= '0;
        end else begin
            lane_load_r <= '0;
            lane_busy_r <= active_s ? ((lane_busy_r & ~lane_done) | load_sel_s) : lane_busy_r;
            if (start_ok_s) begin
                state_r     <= ST_RUN;
                busy_r      <= 1'b1;
                done_r      <= 1'b0;
                next_base_r <= nonce_start;
                limit_r     <= nonce_limit;
                hit_count_r <= 16'd0;
                overflow_r  <= 1'b0;
                exhausted_r <= 1'b0;
                stopped_r   <= 1'b0;
            end else begin
                hit_count_r <= hit_sum_s[16] ? 16'hFFFF : hit_sum_s[15:0];
                overflow_r  <= overflow_r | (|drop_s);
                stopped_r   <= stopped_r | stop_now_s;
                case (state_r)
                    ST_RUN: begin
                        if (|load_sel_s) begin
                            lane_load_r <= load_sel_s;
                            next_base_r <= sum_s[31:0];
                            exhausted_r <= exhaust_now_s;
                            for (int i = 0; i < LANES; i++) begin
                                if (load_sel_s[i]) lane_base_r[32*i +: 32] <= next_base_r;
                            end
                        end
                        if (exhausted_r || stopped_r) state_r <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (!(|lane_busy_r) && !(|hold_valid_r)) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                    default: state_r <= state_r;
                endcase
            end
        end
    end

    // Hold registers and round-robin pointer.
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_r <= '0;
            rr_ptr_r     <= 3'(LANES - 1);
            for (int i = 0; i < LANES; i++) hold_nonce_r[i] <= 32'd0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (capture_s[i]) begin
                    hold_valid_r[i] <= 1'b1;
                    hold_nonce_r[i] <= lane_hit_nonce[32*i +: 32];
                end else if (drain_sel_s[i]) begin
                    hold_valid_r[i] <= 1'b0;
                end
            end
            if (push_s) rr_ptr_r <= xfer_lane_s;
        end
    end

    // Result FIFO storage and pointers.
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_nonce_r[i] <= 32'd0;
                fifo_lane_r[i]  <= 3'd0;
            end
        end else begin
            if (push_s) begin
                fifo_nonce_r[wr_ptr_r] <= hold_nonce_r[xfer_lane_s];
                fifo_lane_r[wr_ptr_r]  <= xfer_lane_s;
                wr_ptr_r               <= wr_ptr_r + 1'b1;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 1'b1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 1'b1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    assign res_nonce = res_valid ? fifo_nonce_r[rd_ptr_r] : 32'd0;
    assign res_lane  = res_valid ? fifo_lane_r[rd_ptr_r]  : 3'd0;
    assign lane_load = lane_load_r;
    assign lane_base = lane_base_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign overflow  = overflow_r;
    assign hit_count = hit_count_r;

endmodule
